// File: rtl/conv1d_tern_thresh_pool.sv
// Streaming 1-D ternary convolution: KSZ-tap window, registered accumulate,
// registered threshold, then OR max-pool of POOL conv outputs per output word.
module conv1d_tern_thresh_pool #(
  parameter int unsigned CH_IN  = 2,
  parameter int unsigned BW_IN  = 8,
  parameter int unsigned KSZ    = 3,
  parameter int unsigned NF     = 256,
  parameter int unsigned POOL   = 2,
  parameter int unsigned ACC_BW = 16,
  parameter logic [NF*KSZ*CH_IN-1:0] W_POS  = '0,
  parameter logic [NF*KSZ*CH_IN-1:0] W_NEG  = '0,
  parameter logic [NF*ACC_BW-1:0]    THRESH = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_in,
  input  logic                   sof_in,
  input  logic [CH_IN*BW_IN-1:0] data_in,
  output logic                   vld_out,
  output logic [NF-1:0]          data_out
);

  localparam int unsigned FW = $clog2(KSZ + 1);
  localparam int unsigned PW = $clog2(POOL + 1);
  localparam logic [FW-1:0] KSZ_F  = FW'(KSZ);
  localparam logic [PW-1:0] PLAST  = PW'(POOL - 1);

  logic [KSZ-1:0][CH_IN-1:0][BW_IN-1:0] win_d, win_q;
  logic [FW-1:0]                        fill_d, fill_q;
  logic                                 v0_d, v0_q, v1_d, v1_q, v2_d, v2_q;
  logic [NF-1:0][ACC_BW-1:0]            acc_d, acc_q;
  logic [NF-1:0]                        bits_d, bits_q;
  logic [NF-1:0]                        pool_d, pool_q;
  logic [PW-1:0]                        pcnt_d, pcnt_q;
  logic [NF-1:0]                        data_out_d, data_out_q;
  logic                                 vld_out_d, vld_out_q;
  logic                                 restart;

  assign restart = vld_in & sof_in;

  // Stage 0: sample window and fill tracking
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    v0_d   = 1'b0;
    if (vld_in) begin
      if (sof_in) begin
        win_d  = '0;
        fill_d = FW'(1);
      end else begin
        for (int unsigned k = 0; k + 1 < KSZ; k++) begin
          win_d[k] = win_q[k+1];
        end
        fill_d = (fill_q == KSZ_F) ? KSZ_F : fill_q + FW'(1);
      end
      win_d[KSZ-1] = data_in;
      v0_d         = (fill_d == KSZ_F);
    end
  end

  // Stage 1: ternary multiply-accumulate over the window
  always_comb begin
    acc_d = '0;
    for (int unsigned f = 0; f < NF; f++) begin
      for (int unsigned k = 0; k < KSZ; k++) begin
        for (int unsigned c = 0; c < CH_IN; c++) begin
          if (W_POS[f*KSZ*CH_IN + k*CH_IN + c] && !W_NEG[f*KSZ*CH_IN + k*CH_IN + c]) begin
            acc_d[f] = acc_d[f] + ACC_BW'($signed(win_q[k][c]));
          end else if (W_NEG[f*KSZ*CH_IN + k*CH_IN + c] && !W_POS[f*KSZ*CH_IN + k*CH_IN + c]) begin
            acc_d[f] = acc_d[f] - ACC_BW'($signed(win_q[k][c]));
          end
        end
      end
    end
    v1_d = v0_q & ~restart;
  end

  // Stage 2: signed threshold per filter
  always_comb begin
    bits_d = '0;
    for (int unsigned f = 0; f < NF; f++) begin
      bits_d[f] = ($signed(acc_q[f]) >= $signed(THRESH[f*ACC_BW +: ACC_BW]));
    end
    v2_d = v1_q & ~restart;
  end

  // Stage 3: OR-pool; a restart drops the partial group and anything in flight
  always_comb begin
    pool_d     = pool_q;
    pcnt_d     = pcnt_q;
    data_out_d = data_out_q;
    vld_out_d  = 1'b0;
    if (restart) begin
      pool_d = '0;
      pcnt_d = '0;
    end else if (v2_q) begin
      if (pcnt_q == PLAST) begin
        data_out_d = pool_q | bits_q;
        vld_out_d  = 1'b1;
        pool_d     = '0;
        pcnt_d     = '0;
      end else begin
        pool_d = pool_q | bits_q;
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= '0;
      fill_q     <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      acc_q      <= '0;
      bits_q     <= '0;
      pool_q     <= '0;
      pcnt_q     <= '0;
      data_out_q <= '0;
      vld_out_q  <= 1'b0;
    end else begin
      win_q      <= win_d;
      fill_q     <= fill_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      acc_q      <= acc_d;
      bits_q     <= bits_d;
      pool_q     <= pool_d;
      pcnt_q     <= pcnt_d;
      data_out_q <= data_out_d;
      vld_out_q  <= vld_out_d;
    end
  end

  assign vld_out  = vld_out_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_conv1d_tern_thresh_pool.sv
// Directed bench for conv1d_tern_thresh_pool: expected pulses (value and edge)
// are queued as stimulus is driven and matched when vld_out fires.
module tb_conv1d_tern_thresh_pool;

  localparam int unsigned NF = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld_in = 1'b0;
  logic          sof_in = 1'b0;
  logic [15:0]   data_in = '0;
  logic          vld_out;
  logic [NF-1:0] data_out;

  // f0 = +ch0 taps, f1 = +ch1 taps, f2 = -ch0 taps, f3 = none
  conv1d_tern_thresh_pool #(
    .CH_IN (2),
    .BW_IN (8),
    .KSZ   (3),
    .NF    (NF),
    .POOL  (2),
    .ACC_BW(16),
    .W_POS (24'h000A95),
    .W_NEG (24'h015000),
    .THRESH({16'd1, 16'd0, 16'd20, 16'd0})
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_in),
    .sof_in  (sof_in),
    .data_in (data_in),
    .vld_out (vld_out),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NF-1:0] data;
    int unsigned   edge_n;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  int          checks = 0;
  int          errors = 0;
  int unsigned edge_cnt = 0;
  int unsigned last_acc = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (vld_out) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed data_out=%h at edge %0d, expected no pulse", data_out, edge_cnt);
      end
      if (sb.size() != 0) begin
        got = sb.pop_front();
        checks++;
        assert (data_out === got.data) else begin
          errors++;
          $error("FAIL pulse_data: observed %h expected %h", data_out, got.data);
        end
        checks++;
        assert (edge_cnt === got.edge_n) else begin
          errors++;
          $error("FAIL pulse_edge: observed edge %0d expected edge %0d", edge_cnt, got.edge_n);
        end
      end
    end
  end

  task automatic beat(input logic v, input logic s, input int c0, input int c1);
    @(negedge clk);
    vld_in  = v;
    sof_in  = s;
    data_in = {8'(c1), 8'(c0)};
    if (v) last_acc = edge_cnt + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 0, 0);
  endtask

  task automatic expect_pulse(input logic [NF-1:0] d);
    exp_t e;
    e.data   = d;
    e.edge_n = last_acc + 3;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    idle(6);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s_missing_pulse: observed %0d pulses outstanding, expected 0", tag, sb.size());
    end
  endtask

  task automatic test1_frame();
    beat(1'b1, 1'b1, 1, 10);
    beat(1'b1, 1'b0, 2, 10);
    beat(1'b1, 1'b0, 3, 10);
    beat(1'b1, 1'b0, 4, 10);
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    assert (vld_out === 1'b0) else begin
      errors++;
      $error("FAIL reset_vld: observed %b expected 0", vld_out);
    end
    checks++;
    assert (data_out === 4'h0) else begin
      errors++;
      $error("FAIL reset_data: observed %h expected 0", data_out);
    end

    // 1: basic frame, one pool group
    test1_frame();
    expect_pulse(4'h3);
    drain("t1");

    // 2: negative ch0
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, i == 0, -5, 10);
    end
    expect_pulse(4'h6);
    drain("t2");
    checks++;
    assert (data_out === 4'h6) else begin
      errors++;
      $error("FAIL hold_data: observed %h expected 6", data_out);
    end

    // 3: gaps between accepted samples; junk data on idle beats
    beat(1'b1, 1'b1, 1, 10);
    beat(1'b0, 1'b1, 77, 77);
    beat(1'b1, 1'b0, 2, 10);
    beat(1'b0, 1'b0, 77, 77);
    beat(1'b1, 1'b0, 3, 10);
    beat(1'b0, 1'b1, 77, 77);
    beat(1'b1, 1'b0, 4, 10);
    expect_pulse(4'h3);
    drain("t3");

    // 4: six samples, two pool groups; f2 sum negative, f3 0 < 1
    for (int i = 1; i <= 6; i++) begin
      beat(1'b1, i == 1, i, 0);
      if (i == 4 || i == 6) expect_pulse(4'h1);
    end
    drain("t4");

    // 5: partial group dropped by a new frame
    beat(1'b1, 1'b1, 1, 10);
    beat(1'b1, 1'b0, 2, 10);
    beat(1'b1, 1'b0, 3, 10);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, i == 0, -5, 10);
    end
    expect_pulse(4'h6);
    drain("t5");

    // 6: reset one cycle after the last sample kills the pending pulse
    test1_frame();
    beat(1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    assert (vld_out === 1'b0) else begin
      errors++;
      $error("FAIL rst_mid_vld: observed %b expected 0", vld_out);
    end
    checks++;
    assert (data_out === 4'h0) else begin
      errors++;
      $error("FAIL rst_mid_data: observed %h expected 0", data_out);
    end
    drain("t6_quiet");
    test1_frame();
    expect_pulse(4'h3);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
